// File: rtl/serial_adder.sv
// serial_adder: bit-serial adder that adds two WIDTH-bit operands one bit per clock, LSB first.
// A single full adder cell is evaluated each cycle. Its carry is registered and fed back as
// the carry-in for the next bit.
//
// Ports:
//   clk    - clock; all state updates on the rising edge
//   rst_n  - asynchronous active-low reset
//   start  - begin an addition (accepted in IDLE or DONE, ignored while busy)
//   a, b   - WIDTH-bit operands, captured when start is accepted
//   cin    - carry-in, captured when start is accepted
//   busy   - high while bits are being shifted through the adder
//   done   - one-cycle pulse when sum/cout take a new value
//   sum    - registered result of the last completed addition
//   cout   - registered carry-out of the last completed addition
module serial_adder #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  // Counter must hold 0..WIDTH-1; keep at least one bit for WIDTH = 1.
  localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

  typedef enum logic [1:0] {
    StIdle,
    StShift,
    StDone
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] sa_q, sa_d;
  logic [WIDTH-1:0] sb_q, sb_d;
  logic [WIDTH-1:0] ps_q, ps_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             c_q, c_d;
  logic             cout_q, cout_d;
  logic [CntW-1:0]  cnt_q, cnt_d;

  // Full adder cell on the current LSBs and the fed-back carry.
  logic fa_s, fa_c;
  assign fa_s = sa_q[0] ^ sb_q[0] ^ c_q;
  assign fa_c = (sa_q[0] & sb_q[0]) | (c_q & (sa_q[0] ^ sb_q[0]));

  // Partial sum with the new bit entering at the MSB; after WIDTH shifts the LSB sits at bit 0.
  logic [WIDTH-1:0] ps_next;
  if (WIDTH == 1) begin : g_ps_w1
    assign ps_next = fa_s;
  end else begin : g_ps_wn
    assign ps_next = {fa_s, ps_q[WIDTH-1:1]};
  end

  always_comb begin
    state_d = state_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    ps_d    = ps_q;
    sum_d   = sum_q;
    c_d     = c_q;
    cout_d  = cout_q;
    cnt_d   = cnt_q;

    case (state_q)
      StIdle: begin
        if (start) begin
          sa_d    = a;
          sb_d    = b;
          c_d     = cin;
          cnt_d   = '0;
          ps_d    = '0;
          state_d = StShift;
        end
      end
      StShift: begin
        ps_d  = ps_next;
        sa_d  = sa_q >> 1;
        sb_d  = sb_q >> 1;
        c_d   = fa_c;
        cnt_d = cnt_q + CntW'(1);
        if (cnt_q == CntLast) begin
          state_d = StDone;
          sum_d   = ps_next;
          cout_d  = fa_c;
        end
      end
      StDone: begin
        // Back-to-back: a start in DONE is captured exactly like one in IDLE.
        if (start) begin
          sa_d    = a;
          sb_d    = b;
          c_d     = cin;
          cnt_d   = '0;
          ps_d    = '0;
          state_d = StShift;
        end else begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      sa_q    <= '0;
      sb_q    <= '0;
      ps_q    <= '0;
      sum_q   <= '0;
      c_q     <= 1'b0;
      cout_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      ps_q    <= ps_d;
      sum_q   <= sum_d;
      c_q     <= c_d;
      cout_q  <= cout_d;
      cnt_q   <= cnt_d;
    end
  end

  assign busy = (state_q == StShift);
  assign done = (state_q == StDone);
  assign sum  = sum_q;
  assign cout = cout_q;

endmodule
